// File: rtl/id_hazard_fwd_ctrl_pkg.sv
// id_hazard_fwd_ctrl_pkg: forward-select codes and downstream dest record shared with the ID/EX operand muxes.
package id_hazard_fwd_ctrl_pkg;
    localparam int GPR_AW = 5;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    typedef struct packed {
        logic              v;
        logic [GPR_AW-1:0] dest;
        logic              we;
        logic              ld;
    } rec_t;
endpackage

// File: rtl/id_hazard_fwd_ctrl_fwd_pick.sv
// fwd_pick: priority match of one ID source against the EX/MEM/WB dest records, youngest first.
module fwd_pick
    import id_hazard_fwd_ctrl_pkg::*;
#(
    parameter int AW = GPR_AW
) (
    input  rec_t          rec_ex_i,
    input  rec_t          rec_mem_i,
    input  rec_t          rec_wb_i,
    input  logic [AW-1:0] raddr_i,
    input  logic          use_i,
    output logic [1:0]    sel_o
);
    logic [GPR_AW-1:0] addr;
    logic hit_ex, hit_mem, hit_wb;

    assign addr    = GPR_AW'(raddr_i);
    assign hit_ex  = rec_ex_i.v  & rec_ex_i.we  & (rec_ex_i.dest  == addr) & use_i;
    assign hit_mem = rec_mem_i.v & rec_mem_i.we & (rec_mem_i.dest == addr) & use_i;
    assign hit_wb  = rec_wb_i.v  & rec_wb_i.we  & (rec_wb_i.dest  == addr) & use_i;
    assign sel_o   = hit_ex ? FWD_EX : hit_mem ? FWD_MEM : hit_wb ? FWD_WB : FWD_RF;
endmodule

// File: rtl/id_hazard_fwd_ctrl.sv
// id_hazard_fwd_ctrl: picks the forward source for each ID operand and stalls ID on load-use hazards.
// Keeps shadow dest records of EX/MEM/WB that advance on the pipeline's own handshakes.
module id_hazard_fwd_ctrl
    import id_hazard_fwd_ctrl_pkg::*;
#(
    parameter int AW         = GPR_AW,
    parameter bit MEM_LD_FWD = 1'b1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_raddr1,
    input  logic [AW-1:0]    id_raddr2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [AW-1:0]    id_dest,
    input  logic             id_we,
    input  logic             id_is_load,
    input  logic             ex_allow,
    input  logic             ex_fire,
    input  logic             mem_fire,
    input  logic             wb_fire,
    input  logic             flush_ex,
    output logic [1:0]       fwd_sel1,
    output logic [1:0]       fwd_sel2,
    output logic             stall,
    output logic             id_fire,
    output logic [CNT_W-1:0] stall_cnt
);
    rec_t rec_ex_q, rec_ex_d, rec_mem_q, rec_mem_d, rec_wb_q, rec_wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [1:0] sel1, sel2;
    logic lu1, lu2;

    fwd_pick #(.AW(AW)) u_pick1 (
        .rec_ex_i (rec_ex_q),
        .rec_mem_i(rec_mem_q),
        .rec_wb_i (rec_wb_q),
        .raddr_i  (id_raddr1),
        .use_i    (id_use1),
        .sel_o    (sel1)
    );

    fwd_pick #(.AW(AW)) u_pick2 (
        .rec_ex_i (rec_ex_q),
        .rec_mem_i(rec_mem_q),
        .rec_wb_i (rec_wb_q),
        .raddr_i  (id_raddr2),
        .use_i    (id_use2),
        .sel_o    (sel2)
    );

    // Load data is not ready in EX; in MEM only when the MEM-stage forward path exists.
    assign lu1 = (sel1 == FWD_EX && rec_ex_q.ld) || (sel1 == FWD_MEM && rec_mem_q.ld && !MEM_LD_FWD);
    assign lu2 = (sel2 == FWD_EX && rec_ex_q.ld) || (sel2 == FWD_MEM && rec_mem_q.ld && !MEM_LD_FWD);

    assign stall     = id_valid & (lu1 | lu2);
    assign fwd_sel1  = id_valid ? sel1 : FWD_RF;
    assign fwd_sel2  = id_valid ? sel2 : FWD_RF;
    assign id_fire   = id_valid & ex_allow & ~stall;
    assign stall_cnt = stall_cnt_q;

    // A newly issued instruction replaces a flushed one, so id_fire outranks flush_ex.
    always_comb begin
        rec_ex_d = rec_ex_q;
        if (id_fire)
            rec_ex_d = '{v: 1'b1, dest: GPR_AW'(id_dest), we: id_we & (|id_dest), ld: id_is_load};
        else if (ex_fire | flush_ex)
            rec_ex_d.v = 1'b0;
        rec_mem_d = rec_mem_q;
        if (ex_fire) begin
            rec_mem_d   = rec_ex_q;
            rec_mem_d.v = rec_ex_q.v & ~flush_ex;
        end else if (mem_fire)
            rec_mem_d.v = 1'b0;
        rec_wb_d = rec_wb_q;
        if (mem_fire)
            rec_wb_d = rec_mem_q;
        else if (wb_fire)
            rec_wb_d.v = 1'b0;
        stall_cnt_d = stall_cnt_q + CNT_W'(stall & ~&stall_cnt_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rec_ex_q    <= '0;
            rec_mem_q   <= '0;
            rec_wb_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            rec_ex_q    <= rec_ex_d;
            rec_mem_q   <= rec_mem_d;
            rec_wb_q    <= rec_wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule
